// File: rtl/month_calendar_seq_if.sv
// Purpose : bundle of tick/load controls and calendar outputs for month_calendar_seq.
// Latency : n/a (signal bundle only).
// Backpressure: none; the calendar accepts tick/load every cycle.
//
// Signals:
//   tick        advance one day
//   load        preload request
//   load_month  month index to load (0..11)
//   load_day    day to load (1..month length)
//   leap        current year is leap (only honoured with MONTH_CAL_LEAP_EN)
//   m           one-hot month (m[0]=January)
//   day         current day 1..31
//   month_len   length of current month (combinational)
//   month_end   one-cycle pulse when the month rolls over
//   year_wrap   one-cycle pulse when December rolls to January
//   load_err    one-cycle pulse when a load is rejected
interface month_calendar_seq_if;
  logic        tick;
  logic        load;
  logic [3:0]  load_month;
  logic [4:0]  load_day;
  logic        leap;
  logic [11:0] m;
  logic [4:0]  day;
  logic [4:0]  month_len;
  logic        month_end;
  logic        year_wrap;
  logic        load_err;

  // Stimulus side: drives controls, observes calendar state.
  modport master (
    output tick, load, load_month, load_day, leap,
    input  m, day, month_len, month_end, year_wrap, load_err
  );

  // Calendar side.
  modport slave (
    input  tick, load, load_month, load_day, leap,
    output m, day, month_len, month_end, year_wrap, load_err
  );
endinterface

// File: rtl/month_calendar_seq.sv
// Purpose : day-by-day month/day calendar with preload, month-end and year-wrap strobes.
// Latency : one clock from tick/load to updated m/day/strobes; month_len is combinational.
// Backpressure: none; every tick/load is consumed in the cycle it is presented.
//
// Ports:
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset, dominates load and tick
//   cal  month_calendar_seq_if.slave (tick/load controls in, m/day/strobes out)
// Optional feature: define MONTH_CAL_LEAP_EN to honour cal.leap (February = 28 + leap);
// otherwise February is always 28 days and a load of Feb 29 is rejected.
module month_calendar_seq #(
  parameter int START_MONTH = 0,
  parameter int START_DAY   = 1
) (
  input logic                 clk,
  input logic                 rst,
  month_calendar_seq_if.slave cal
);

  logic [3:0]  mi_q, mi_d;
  logic [4:0]  day_q, day_d;
  logic [11:0] m_q, m_d;
  logic        month_end_q, month_end_d;
  logic        year_wrap_q, year_wrap_d;
  logic        load_err_q, load_err_d;

  logic        leap_eff;
  logic [4:0]  cur_len;
  logic [4:0]  ld_len;
  logic        ld_ok;

`ifdef MONTH_CAL_LEAP_EN
  assign leap_eff = cal.leap;
`else
  // Pin kept for compatibility; value deliberately ignored.
  wire unused_leap = cal.leap;
  assign leap_eff = 1'b0;
`endif

  // Month length lookup; out-of-range indices return 0 so any load to them fails.
  function automatic logic [4:0] len_of(input logic [3:0] idx, input logic lp);
    logic [4:0] len;
    case (idx)
      4'd0, 4'd2, 4'd4, 4'd6, 4'd7, 4'd9, 4'd11: len = 5'd31;
      4'd3, 4'd5, 4'd8, 4'd10:                   len = 5'd30;
      4'd1:                                      len = lp ? 5'd29 : 5'd28;
      default:                                   len = 5'd0;
    endcase
    return len;
  endfunction

  assign cur_len = len_of(mi_q, leap_eff);
  assign ld_len  = len_of(cal.load_month, leap_eff);
  assign ld_ok   = (cal.load_month <= 4'd11) && (cal.load_day != 5'd0) &&
                   (cal.load_day <= ld_len);

  always_comb begin
    mi_d        = mi_q;
    day_d       = day_q;
    month_end_d = 1'b0;
    year_wrap_d = 1'b0;
    load_err_d  = 1'b0;
    if (cal.load) begin
      // A load, valid or not, swallows any simultaneous tick.
      if (ld_ok) begin
        mi_d  = cal.load_month;
        day_d = cal.load_day;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (cal.tick) begin
      // >= rather than == so a day stranded past a shortened February still rolls.
      if (day_q >= cur_len) begin
        day_d       = 5'd1;
        month_end_d = 1'b1;
        if (mi_q == 4'd11) begin
          mi_d        = 4'd0;
          year_wrap_d = 1'b1;
        end else begin
          mi_d = mi_q + 4'd1;
        end
      end else begin
        day_d = day_q + 5'd1;
      end
    end
    m_d = 12'd1 << mi_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mi_q        <= 4'(START_MONTH);
      day_q       <= 5'(START_DAY);
      m_q         <= 12'd1 << START_MONTH;
      month_end_q <= 1'b0;
      year_wrap_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      mi_q        <= mi_d;
      day_q       <= day_d;
      m_q         <= m_d;
      month_end_q <= month_end_d;
      year_wrap_q <= year_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign cal.m         = m_q;
  assign cal.day       = day_q;
  assign cal.month_len = cur_len;
  assign cal.month_end = month_end_q;
  assign cal.year_wrap = year_wrap_q;
  assign cal.load_err  = load_err_q;

endmodule

// File: tb/tb_month_calendar_seq.sv
// Purpose : directed self-checking bench for month_calendar_seq.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: n/a.
module tb_month_calendar_seq;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  month_calendar_seq_if cal_if ();

  month_calendar_seq #(.START_MONTH(0), .START_DAY(1)) dut (
    .clk (clk),
    .rst (rst),
    .cal (cal_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] mo, input logic [4:0] dy, input logic tk);
    cal_if.load       = 1'b1;
    cal_if.load_month = mo;
    cal_if.load_day   = dy;
    cal_if.tick       = tk;
    step();
    cal_if.load = 1'b0;
    cal_if.tick = 1'b0;
  endtask

  // Reference month lengths with leap off.
  int lens [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  logic [3:0] bad_mo [3] = '{4'd12, 4'd3, 4'd4};
  logic [4:0] bad_dy [3] = '{5'd5, 5'd31, 5'd0};

  int exp_mi, exp_day;
  bit exp_me, exp_yw;
  int me_count;

  initial begin
    rst               = 1'b1;
    cal_if.tick       = 1'b0;
    cal_if.load       = 1'b0;
    cal_if.load_month = 4'd0;
    cal_if.load_day   = 5'd1;
    cal_if.leap       = 1'b0;
    step();
    step();
    chk("rst_m", cal_if.m, 32'h001);
    chk("rst_day", cal_if.day, 1);
    chk("rst_me", cal_if.month_end, 0);
    chk("rst_yw", cal_if.year_wrap, 0);
    chk("rst_lerr", cal_if.load_err, 0);

    // Reset holds state even with tick asserted.
    cal_if.tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tick_m", cal_if.m, 32'h001);
      chk("rst_tick_day", cal_if.day, 1);
    end
    cal_if.tick = 1'b0;
    rst = 1'b0;
    step();
    chk("jan_len", cal_if.month_len, 31);

    // Jan 30 -> Jan 31 -> Feb 1.
    do_load(4'd0, 5'd30, 1'b0);
    chk("ld_jan30_day", cal_if.day, 30);
    chk("ld_jan30_lerr", cal_if.load_err, 0);
    cal_if.tick = 1'b1;
    step();
    chk("jan31_day", cal_if.day, 31);
    chk("jan31_me", cal_if.month_end, 0);
    step();
    cal_if.tick = 1'b0;
    chk("feb1_m", cal_if.m, 32'h002);
    chk("feb1_day", cal_if.day, 1);
    chk("feb1_me", cal_if.month_end, 1);
    chk("feb1_yw", cal_if.year_wrap, 0);
    chk("feb_len", cal_if.month_len, 28);
    step();
    chk("feb1_me_clear", cal_if.month_end, 0);
    chk("feb1_hold_day", cal_if.day, 1);

    // Dec 31 -> Jan 1 with year wrap.
    do_load(4'd11, 5'd31, 1'b0);
    chk("ld_dec31_m", cal_if.m, 32'h800);
    cal_if.tick = 1'b1;
    step();
    cal_if.tick = 1'b0;
    chk("wrap_m", cal_if.m, 32'h001);
    chk("wrap_day", cal_if.day, 1);
    chk("wrap_me", cal_if.month_end, 1);
    chk("wrap_yw", cal_if.year_wrap, 1);
    step();
    chk("wrap_yw_clear", cal_if.year_wrap, 0);

    // Feb 28 with leap requested.
    cal_if.leap = 1'b1;
    do_load(4'd1, 5'd28, 1'b0);
    chk("ld_feb28_day", cal_if.day, 28);
    cal_if.tick = 1'b1;
    step();
    cal_if.tick = 1'b0;
`ifdef MONTH_CAL_LEAP_EN
    chk("leap_len", cal_if.month_len, 29);
    chk("leap_feb29_m", cal_if.m, 32'h002);
    chk("leap_feb29_day", cal_if.day, 29);
    chk("leap_feb29_me", cal_if.month_end, 0);
    // Leap drops while on Feb 29: next tick must roll to Mar 1.
    cal_if.leap = 1'b0;
    cal_if.tick = 1'b1;
    step();
    cal_if.tick = 1'b0;
    chk("leapdrop_m", cal_if.m, 32'h004);
    chk("leapdrop_day", cal_if.day, 1);
    chk("leapdrop_me", cal_if.month_end, 1);
`else
    chk("noleap_m", cal_if.m, 32'h004);
    chk("noleap_day", cal_if.day, 1);
    chk("noleap_me", cal_if.month_end, 1);
    // Feb 29 must be refused when leap support is compiled out.
    do_load(4'd1, 5'd29, 1'b0);
    chk("noleap_feb29_lerr", cal_if.load_err, 1);
    chk("noleap_feb29_m", cal_if.m, 32'h004);
`endif
    cal_if.leap = 1'b0;

    // Invalid loads leave state untouched; first set a known state (Jun 10).
    do_load(4'd5, 5'd10, 1'b0);
    chk("ld_jun10_m", cal_if.m, 32'h020);
    for (int i = 0; i < 3; i++) begin
      do_load(bad_mo[i], bad_dy[i], 1'b0);
      chk($sformatf("bad%0d_lerr", i), cal_if.load_err, 1);
      chk($sformatf("bad%0d_m", i), cal_if.m, 32'h020);
      chk($sformatf("bad%0d_day", i), cal_if.day, 10);
      step();
      chk($sformatf("bad%0d_lerr_clear", i), cal_if.load_err, 0);
    end
    // Invalid load with tick: the tick is also discarded.
    do_load(4'd3, 5'd31, 1'b1);
    chk("badtick_lerr", cal_if.load_err, 1);
    chk("badtick_day", cal_if.day, 10);

    // Valid load with simultaneous tick: Jul 15, no increment.
    do_load(4'd6, 5'd15, 1'b1);
    chk("ldtick_m", cal_if.m, 32'h040);
    chk("ldtick_day", cal_if.day, 15);
    chk("ldtick_me", cal_if.month_end, 0);

    // 200 consecutive ticks against a reference walk.
    exp_mi   = 6;
    exp_day  = 15;
    me_count = 0;
    cal_if.tick = 1'b1;
    for (int i = 0; i < 200; i++) begin
      exp_me = 1'b0;
      exp_yw = 1'b0;
      if (exp_day >= lens[exp_mi]) begin
        exp_day = 1;
        exp_me  = 1'b1;
        me_count++;
        if (exp_mi == 11) begin
          exp_mi = 0;
          exp_yw = 1'b1;
        end else begin
          exp_mi++;
        end
      end else begin
        exp_day++;
      end
      step();
      chk("run_onehot", $countones(cal_if.m), 1);
      chk("run_m", cal_if.m, 32'(1) << exp_mi);
      chk("run_day", cal_if.day, exp_day);
      chk("run_me", cal_if.month_end, exp_me);
      chk("run_yw", cal_if.year_wrap, exp_yw);
    end
    cal_if.tick = 1'b0;
    // Jul 15 + 200 days = Jan 31: six month boundaries crossed.
    chk("run_me_count", me_count, 6);
    chk("run_end_m", cal_if.m, 32'h001);
    chk("run_end_day", cal_if.day, 31);

    // Reset mid-sequence beats a pending valid load and a tick that would wrap.
    cal_if.load       = 1'b1;
    cal_if.load_month = 4'd11;
    cal_if.load_day   = 5'd31;
    cal_if.tick       = 1'b1;
    rst               = 1'b1;
    step();
    cal_if.load = 1'b0;
    cal_if.tick = 1'b0;
    rst         = 1'b0;
    chk("midrst_m", cal_if.m, 32'h001);
    chk("midrst_day", cal_if.day, 1);
    chk("midrst_me", cal_if.month_end, 0);
    chk("midrst_lerr", cal_if.load_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/month_calendar_seq.md
Name: month_calendar_seq

Overview:
- Sequential month/day calendar generator.
- Produces the 12-line one-hot month bus (m[0]=January … m[11]=December) consumed by the months encoder.
- Walks day-by-day on a tick strobe and can be preloaded.
- Emits month-end and year-wrap strobes for downstream logging and display logic.

Parameters:
START_MONTH, 0, month index (0..11) loaded at reset
START_DAY, 1, day-of-month (1..28) loaded at reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
tick  input  1  advance one day this cycle
load  input  1  preload request, sampled on clk edge
load_month  input  4  month index to load (valid 0..11)
load_day  input  5  day to load (valid 1..month length)
leap  input  1  current year is leap (Feb = 29 days), see optional feature
m  output  12  one-hot month, registered
day  output  5  current day 1..31, registered
month_len  output  5  length of current month, combinational from m and leap
month_end  output  1  one-cycle pulse: month rolled over
year_wrap  output  1  one-cycle pulse: December rolled to January
load_err  output  1  one-cycle pulse: rejected load

Behaviour:
- Reset (rst=1 at clk edge) dominates everything:
  - m = 1<<START_MONTH, day = START_DAY.
  - month_end = 0, year_wrap = 0, load_err = 0.
- Internal state: 4-bit month index mi (0..11) and 5-bit day.
  - m is the registered one-hot decode of mi; exactly one bit of m is set at all times.
- Month lengths:
  - 31 days: mi 0, 2, 4, 6, 7, 9, 11.
  - 30 days: mi 3, 5, 8, 10.
  - 28 days: mi 1, or 29 days when leap is effective.
- Priority each cycle: rst > load > tick.
- Load (load=1):
  - Valid load: load_month ≤ 11 and 1 ≤ load_day ≤ length of load_month (using the current leap). Next cycle mi = load_month, day = load_day; a simultaneous tick is discarded.
  - Invalid load: state unchanged, load_err = 1 for exactly one cycle; a simultaneous tick is also discarded.
- Tick (tick=1, load=0):
  - day < month_len: day increments.
  - day == month_len: day becomes 1, mi increments, month_end pulses one cycle.
  - mi was 11: mi becomes 0 and year_wrap pulses in the same cycle as month_end.
- Latency: one clock from tick/load edge to updated m/day/strobes.
- Strobes are 0 in every cycle not explicitly pulsed; back-to-back ticks give back-to-back days with no bubbles.
- leap is sampled live. If leap drops while day = 29 in February, the next tick treats day ≥ month_len as end-of-month and rolls to 1 March. The same rule (day ≥ month_len ⇒ roll) applies in all months.
- Reset mid-sequence is legal any cycle; it discards pending load/tick and suppresses that cycle's strobes.

Optional Feature:
- Macro: MONTH_CAL_LEAP_EN.
- Defined: leap input honoured; February length = 28 + leap.
- Not defined: leap ignored (port kept for pin compatibility); February is always 28 days; load of Feb 29 is rejected with load_err.

Test Plan:
- Reset with defaults → m=12'b000000000001, day=1, all strobes 0; hold rst with tick=1 for 3 cycles → state unchanged.
- Load month 0 day 30, tick ×2 → day 31 then m=12'b000000000010, day=1, month_end=1 for one cycle, year_wrap=0.
- Load month 11 day 31, tick → m=12'b000000000001, day=1, month_end=1 and year_wrap=1 in the same cycle.
- Load month 1 day 28 with leap=1, tick → day 29, m unchanged (with MONTH_CAL_LEAP_EN); without the macro → m=12'b000000000100, day=1.
- Loads (month 12, day 5), (month 3, day 31), (month 4, day 0) → load_err pulse each time, m/day unchanged.
- load and tick both high with valid month 6 day 15 → m=12'b000001000000, day=15, no increment; a following 200 consecutive ticks → exactly one bit of m set every cycle, month_end pulses match expected month boundaries.
